// File: rtl/seg7_scan_mux_if.sv
// Bus between the register-file side and the 7-segment scan driver:
// display data and load strobe in, board pins and frame pulse out.
interface seg7_scan_mux_if #(parameter int N_DIGITS = 8);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lz_suppress;
  logic                  load;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            a_to_g;
  logic                  dp;
  logic                  frame_done;

  modport master (output value, dp_in, digit_en, lz_suppress, load,
                  input  an, a_to_g, dp, frame_done);
  modport slave  (input  value, dp_in, digit_en, lz_suppress, load,
                  output an, a_to_g, dp, frame_done);
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with a blank guard at the start
// of each slot, leading-zero blanking and a frame-synchronous display buffer.
module seg7_scan_mux #(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 2000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  seg7_scan_mux_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam bit AL = (ACTIVE_LOW != 0);

  typedef struct packed {
    logic [N_DIGITS-1:0][3:0] value;
    logic [N_DIGITS-1:0]      dp_in;
    logic [N_DIGITS-1:0]      digit_en;
    logic                     lz_suppress;
  } disp_t;

  disp_t               in_w, pend, act;
  logic                pend_valid;
  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [N_DIGITS-1:0] supp;
  logic                pre_wrap, frame_wrap, vis, dp_on;
  logic [3:0]          nib;
  logic [N_DIGITS-1:0] an_on;
  logic [6:0]          seg_on;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign in_w       = {bus.value, bus.dp_in, bus.digit_en, bus.lz_suppress};
  assign pre_wrap   = (pre == PRE_LAST);
  assign frame_wrap = pre_wrap && (idx == IDX_LAST);

  // Walk down from the top digit; a digit stays suppressed only while every
  // digit above it is also zero. Digit 0 is always shown.
  always_comb begin
    logic zero_above;
    zero_above = act.lz_suppress;
    supp       = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (act.value[k] == 4'h0);
      supp[k]    = zero_above;
    end
  end

  always_comb begin
    nib    = act.value[idx];
    vis    = act.digit_en[idx] && !supp[idx] && (pre >= PRE_BLANK);
    an_on  = vis ? (N_DIGITS'(1) << idx) : '0;
    seg_on = vis ? ~glyph(nib) : 7'h00;
    dp_on  = vis && act.dp_in[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre            <= '0;
      idx            <= '0;
      pend           <= '0;
      act            <= '0;
      pend_valid     <= 1'b0;
      bus.an         <= {N_DIGITS{AL}};
      bus.a_to_g     <= {7{AL}};
      bus.dp         <= AL;
      bus.frame_done <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (bus.load) pend <= in_w;
      // A load landing on the wrap edge bypasses pend so it shows this frame.
      if (frame_wrap) begin
        if (bus.load)       act <= in_w;
        else if (pend_valid) act <= pend;
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_valid <= 1'b1;
      end
      bus.an         <= AL ? ~an_on : an_on;
      bus.a_to_g     <= AL ? ~seg_on : seg_on;
      bus.dp         <= AL ? ~dp_on : dp_on;
      bus.frame_done <= frame_wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: a 4-digit active-low instance and a 1-digit
// active-high instance scanned together against a frame-level reference.
module tb_seg7_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.N_DIGITS(4)) b4 ();
  seg7_scan_mux_if #(.N_DIGITS(1)) b1 ();

  seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1))
    dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  seg7_scan_mux #(.N_DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct packed {
    logic [15:0] v; logic [3:0] dp; logic [3:0] en; logic lz;
  } fr_t;
  typedef struct packed {
    logic [3:0] an; logic [6:0] seg; logic dp; logic fd;
    logic an1; logic [6:0] seg1; logic dp1; logic fd1;
  } obs_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  fr_t  sh4, pd4, sh1, pd1;
  bit   pv4, pv1;
  int   n;
  obs_t q[$];
  obs_t got, exp;
  int   n_cmp, n_bad;
  obs_t got_w;
  assign got_w = {b4.an, b4.a_to_g, b4.dp, b4.frame_done,
                  b1.an, b1.a_to_g, b1.dp, b1.frame_done};

  // Expected pins on cycle e (counted from reset release) for a frame built
  // from nd slots of 4 cycles, first cycle of each slot blank.
  function automatic logic [12:0] model(input fr_t f, input int e, input int nd, input bit al);
    int p, k, w;
    bit vis, zero, fd;
    logic [3:0] an_on, nibv;
    logic [6:0] seg_on;
    logic dp_on;
    p = ((e - 1) % (4 * nd)) + 1;
    k = (p - 1) / 4;
    w = p - 4 * k;
    nibv = f.v[4*k +: 4];
    zero = f.lz && (k > 0);
    for (int j = k; j < nd; j++) if (f.v[4*j +: 4] != 4'h0) zero = 1'b0;
    vis    = (w >= 2) && f.en[k] && !zero;
    an_on  = vis ? 4'(1 << k) : 4'h0;
    seg_on = vis ? ~GLYPH[nibv] : 7'h00;
    dp_on  = vis && f.dp[k];
    fd     = (e % (4 * nd)) == 0;
    if (al) return {~an_on, ~seg_on, ~dp_on, fd};
    return {an_on, seg_on, dp_on, fd};
  endfunction

  // Push the expectation for the coming edge, advance the frame model, clock.
  task automatic tick();
    logic [12:0] m4, m1;
    fr_t in4, in1;
    bit r;
    r = rst;
    if (r) begin
      m4 = {4'hF, 7'h7F, 1'b1, 1'b0};
      m1 = 13'h0;
    end else begin
      m4 = model(sh4, n + 1, 4, 1'b1);
      m1 = model(sh1, n + 1, 1, 1'b0);
    end
    exp = {m4[12:9], m4[8:2], m4[1], m4[0], m1[9], m1[8:2], m1[1], m1[0]};
    q.push_back(exp);
    in4 = {b4.value, b4.dp_in, b4.digit_en, b4.lz_suppress};
    in1 = {12'h0, b1.value, 3'b0, b1.dp_in, 3'b0, b1.digit_en, b1.lz_suppress};
    if (r) begin
      sh4 = '0; pd4 = '0; pv4 = 0; sh1 = '0; pd1 = '0; pv1 = 0;
    end else begin
      if ((n + 1) % 16 == 0) begin
        if (b4.load) sh4 = in4; else if (pv4) sh4 = pd4;
        pv4 = 0;
      end else if (b4.load) begin pd4 = in4; pv4 = 1; end
      if ((n + 1) % 4 == 0) begin
        if (b1.load) sh1 = in1; else if (pv1) sh1 = pd1;
        pv1 = 0;
      end else if (b1.load) begin pd1 = in1; pv1 = 1; end
    end
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
  endtask

  task automatic load4(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d, input logic lz);
    b4.value = v; b4.digit_en = en; b4.dp_in = d; b4.lz_suppress = lz; b4.load = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 18; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      exp = q.pop_front(); got = got_w; n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL reset_first_frame cyc=%0d got=%h want=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_load_scan();
    load4(16'hA5C1, 4'hF, 4'b0010, 1'b0);
    for (int i = 0; i < 41; i++) begin
      tick();
      b4.load = 1'b0;
      exp = q.pop_front(); got = got_w; n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL load_scan cyc=%0d got=%h want=%h", n, got, exp);
      end
      if (n > 32 && n % 16 == 7) begin
        n_cmp++;
        if ({b4.an, b4.a_to_g, b4.dp} !== {4'b1101, 7'b1000110, 1'b0}) begin
          n_bad++; $display("FAIL load_scan_digit1 cyc=%0d got=%b_%b_%b want=1101_1000110_0",
                            n, b4.an, b4.a_to_g, b4.dp);
        end
      end
    end
  endtask

  task automatic test_lz();
    for (int s = 0; s < 2; s++) begin
      load4(s == 0 ? 16'h0070 : 16'h0000, 4'hF, 4'h0, 1'b1);
      for (int i = 0; i < 37; i++) begin
        tick();
        b4.load = 1'b0;
        exp = q.pop_front(); got = got_w; n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL lz_suppress set=%0d cyc=%0d got=%h want=%h", s, n, got, exp);
        end
      end
    end
  endtask

  task automatic test_tear();
    // Each row: cycles to idle first (to a frame phase), then loads on
    // consecutive ticks separated by 'gap' idle ticks.
    logic [15:0] va, vb;
    int phase, gap;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin va = 16'h1111; vb = 16'h2222; phase = 5;  gap = 1; end
        1: begin va = 16'h1234; vb = 16'h5678; phase = 3;  gap = 0; end
        default: begin va = 16'h9E4B; vb = 16'h9E4B; phase = 15; gap = 0; end
      endcase
      for (int i = 0; i < 16 && (n % 16) != phase; i++) begin
        tick();
        exp = q.pop_front(); got = got_w; n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL tear_align cyc=%0d got=%h want=%h", n, got, exp);
        end
      end
      for (int i = 0; i < 40; i++) begin
        if (i == 0) load4(va, 4'hF, 4'b0101, 1'b0);
        else if (i == gap + 1) load4(vb, 4'hF, 4'b0101, 1'b0);
        tick();
        b4.load = 1'b0;
        exp = q.pop_front(); got = got_w; n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL tear_free set=%0d cyc=%0d got=%h want=%h", s, n, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16 && (n % 16) != 10; i++) begin
      tick();
      exp = q.pop_front(); got = got_w; n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL reset_mid_align cyc=%0d got=%h want=%h", n, got, exp);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      rst = 1'b0;
      exp = q.pop_front(); got = got_w; n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_single_digit();
    b1.value = 4'h8; b1.digit_en = 1'b1; b1.dp_in = 1'b1; b1.load = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      b1.load = 1'b0;
      exp = q.pop_front(); got = got_w; n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL single_digit cyc=%0d got=%h want=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    n = 0; n_cmp = 0; n_bad = 0;
    sh4 = '0; pd4 = '0; sh1 = '0; pd1 = '0; pv4 = 0; pv1 = 0;
    b4.value = '0; b4.dp_in = '0; b4.digit_en = '0; b4.lz_suppress = 1'b0; b4.load = 1'b0;
    b1.value = '0; b1.dp_in = '0; b1.digit_en = '0; b1.lz_suppress = 1'b0; b1.load = 1'b0;
    test_reset();
    test_load_scan();
    test_lz();
    test_tear();
    test_reset_mid();
    test_single_digit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
